// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, forwarding-mux select encoding and the
// per-stage hazard record.
package pipe_pkg;

   localparam int ADDR_W = 5;
   localparam int TNEW_W = 2;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_W  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;

   typedef struct packed {
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] rt;
      logic [ADDR_W-1:0] a3;
      logic [TNEW_W-1:0] tnew;
   } stage_rec_t;

endpackage

// File: rtl/fwd_sel_gen.sv
// Forwarding select for one source operand: the M-stage value wins over W when
// both hold the register; $0 never forwards.
module fwd_sel_gen
   import pipe_pkg::*;
(
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] m_a3,
   input  logic [TNEW_W-1:0] m_tnew,
   input  logic [ADDR_W-1:0] w_a3,
   output logic [1:0]        sel
);

   logic m_hit;
   logic w_hit;

   assign m_hit = (src != '0) && (m_a3 == src) && (m_tnew == '0);
   assign w_hit = (src != '0) && (w_a3 == src);

   always_comb begin
      sel = FWD_RF;
      if (m_hit) begin
         sel = FWD_M;
      end else if (w_hit) begin
         sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Tracks destination/Tnew records for E, M and W and derives the D/E operand
// forwarding selects plus the D-stage stall.
module hazard_forward_ctrl
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] D_rs,
   input  logic [ADDR_W-1:0] D_rt,
   input  logic [TNEW_W-1:0] D_Tuse_rs,
   input  logic [TNEW_W-1:0] D_Tuse_rt,
   input  logic [ADDR_W-1:0] D_A3,
   input  logic [TNEW_W-1:0] D_TnewE,
   output logic              stall,
   output logic [1:0]        D_ForwardRD1Mux_Sel,
   output logic [1:0]        D_ForwardRD2Mux_Sel,
   output logic [1:0]        E_ForwardRD1Mux_Sel,
   output logic [1:0]        E_ForwardRD2Mux_Sel
);

   stage_rec_t        e_rec_reg;
   logic [ADDR_W-1:0] m_a3_reg;
   logic [TNEW_W-1:0] m_tnew_reg;
   logic [ADDR_W-1:0] w_a3_reg;

   logic [ADDR_W-1:0] src   [4];
   logic [1:0]        sel   [4];
   logic [ADDR_W-1:0] d_src [2];
   logic [TNEW_W-1:0] d_tuse[2];
   logic [1:0]        src_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_rec_reg  <= '0;
         m_a3_reg   <= '0;
         m_tnew_reg <= '0;
         w_a3_reg   <= '0;
      end else begin
         m_a3_reg   <= e_rec_reg.a3;
         m_tnew_reg <= (e_rec_reg.tnew == '0) ? '0 : e_rec_reg.tnew - TNEW_W'(1);
         w_a3_reg   <= m_a3_reg;
         // A stalled D instruction stays put upstream; E takes a bubble.
         if (stall) begin
            e_rec_reg <= '0;
         end else begin
            e_rec_reg <= '{rs: D_rs, rt: D_rt, a3: D_A3, tnew: D_TnewE};
         end
      end
   end

   assign d_src[0]  = D_rs;
   assign d_src[1]  = D_rt;
   assign d_tuse[0] = D_Tuse_rs;
   assign d_tuse[1] = D_Tuse_rt;

   // No E->D forward path exists, so an E match with Tuse 0 always stalls.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_stall
         logic e_match;
         logic m_match;
         assign e_match = (d_src[gi] != '0) && (e_rec_reg.a3 == d_src[gi]);
         assign m_match = (d_src[gi] != '0) && (m_a3_reg == d_src[gi]);
         assign src_stall[gi] =
            (e_match && ((e_rec_reg.tnew > d_tuse[gi]) || (d_tuse[gi] == '0))) ||
            (m_match && (m_tnew_reg > d_tuse[gi]));
      end
   endgenerate

   assign stall = |src_stall;

   assign src[0] = D_rs;
   assign src[1] = D_rt;
   assign src[2] = e_rec_reg.rs;
   assign src[3] = e_rec_reg.rt;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sel
         fwd_sel_gen u_sel (
            .src   (src[gi]),
            .m_a3  (m_a3_reg),
            .m_tnew(m_tnew_reg),
            .w_a3  (w_a3_reg),
            .sel   (sel[gi])
         );
      end
   endgenerate

   assign D_ForwardRD1Mux_Sel = sel[0];
   assign D_ForwardRD2Mux_Sel = sel[1];
   assign E_ForwardRD1Mux_Sel = sel[2];
   assign E_ForwardRD2Mux_Sel = sel[3];

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench: each cycle's stimulus pushes a hand-computed expected
// response; a negedge monitor pops and compares it against the DUT.
module tb_hazard_forward_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] D_rs = '0;
   logic [4:0] D_rt = '0;
   logic [1:0] D_Tuse_rs = '0;
   logic [1:0] D_Tuse_rt = '0;
   logic [4:0] D_A3 = '0;
   logic [1:0] D_TnewE = '0;
   logic       stall;
   logic [1:0] D_ForwardRD1Mux_Sel;
   logic [1:0] D_ForwardRD2Mux_Sel;
   logic [1:0] E_ForwardRD1Mux_Sel;
   logic [1:0] E_ForwardRD2Mux_Sel;

   typedef struct packed {
      logic       stall;
      logic [1:0] d1;
      logic [1:0] d2;
      logic [1:0] e1;
      logic [1:0] e2;
   } resp_t;

   resp_t exp_q[$];
   int    step_q[$];
   int    n_compared = 0;
   int    n_mismatched = 0;
   int    step_no = 0;

   hazard_forward_ctrl dut (
      .clk                (clk),
      .reset              (reset),
      .D_rs               (D_rs),
      .D_rt               (D_rt),
      .D_Tuse_rs          (D_Tuse_rs),
      .D_Tuse_rt          (D_Tuse_rt),
      .D_A3               (D_A3),
      .D_TnewE            (D_TnewE),
      .stall              (stall),
      .D_ForwardRD1Mux_Sel(D_ForwardRD1Mux_Sel),
      .D_ForwardRD2Mux_Sel(D_ForwardRD2Mux_Sel),
      .E_ForwardRD1Mux_Sel(E_ForwardRD1Mux_Sel),
      .E_ForwardRD2Mux_Sel(E_ForwardRD2Mux_Sel)
   );

   always #5 clk = ~clk;

   // One vector per cycle: applied just after the rising edge.
   task automatic step(input logic rst, input int rs, input int rt, input int tur,
                       input int tut, input int a3, input int tn, input logic st,
                       input int d1, input int d2, input int e1, input int e2);
      resp_t r;
      @(posedge clk);
      #1;
      reset     = rst;
      D_rs      = 5'(rs);
      D_rt      = 5'(rt);
      D_Tuse_rs = 2'(tur);
      D_Tuse_rt = 2'(tut);
      D_A3      = 5'(a3);
      D_TnewE   = 2'(tn);
      r.stall = st;
      r.d1 = 2'(d1);
      r.d2 = 2'(d2);
      r.e1 = 2'(e1);
      r.e2 = 2'(e2);
      exp_q.push_back(r);
      step_q.push_back(step_no);
      step_no++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         resp_t e;
         resp_t a;
         int    s;
         e = exp_q.pop_front();
         s = step_q.pop_front();
         a = '{stall: stall, d1: D_ForwardRD1Mux_Sel, d2: D_ForwardRD2Mux_Sel,
               e1: E_ForwardRD1Mux_Sel, e2: E_ForwardRD2Mux_Sel};
         n_compared++;
         if (a !== e) begin
            n_mismatched++;
            $display("FAIL step%0d: got stall=%b d1=%0d d2=%0d e1=%0d e2=%0d, want stall=%b d1=%0d d2=%0d e1=%0d e2=%0d",
                     s, a.stall, a.d1, a.d2, a.e1, a.e2, e.stall, e.d1, e.d2, e.e1, e.e2);
         end else begin
            $display("step%0d: stall=%b d1=%0d d2=%0d e1=%0d e2=%0d ok",
                     s, a.stall, a.d1, a.d2, a.e1, a.e2);
         end
      end
   end

   initial begin
      //    rst rs rt tur tut a3 tn   st d1 d2 e1 e2
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);   // in reset
      // ALU $8 then two readers
      step(1, 1, 2, 1, 1, 8, 1,  0, 0, 0, 0, 0);   // first cycle after release
      step(1, 8, 3, 1, 1, 10, 1, 0, 0, 0, 0, 0);
      step(1, 8, 10, 1, 1, 11, 1, 0, 2, 0, 2, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 2);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      // load $9, beq on rt with Tuse 0: two stall cycles
      step(1, 1, 0, 1, 1, 9, 2,  0, 0, 0, 0, 0);
      step(1, 4, 9, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      step(1, 4, 9, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      step(1, 4, 9, 0, 0, 0, 0,  0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      // load $9, ALU consumer Tuse 1: one stall cycle, no M forward at Tnew 1
      step(1, 2, 0, 1, 1, 9, 2,  0, 0, 0, 0, 0);
      step(1, 9, 5, 1, 1, 12, 1, 1, 0, 0, 0, 0);
      step(1, 9, 5, 1, 1, 12, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      // jal $31 then jr $31
      step(1, 0, 0, 0, 0, 31, 0, 0, 0, 0, 0, 0);
      step(1, 31, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 31, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      // writes and reads of $0
      step(1, 0, 0, 0, 0, 0, 2,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
      // M and W both holding $5
      step(1, 0, 0, 0, 0, 5, 1,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5, 1,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 5, 5, 1, 2, 0, 0,  0, 2, 2, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
      // store data (Tuse 2) behind a load: no stall
      step(1, 0, 0, 1, 1, 7, 2,  0, 0, 0, 0, 0);
      step(1, 1, 7, 1, 2, 0, 0,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      // load records, then reset mid-run where D_Fwd1 would otherwise be 2
      step(1, 0, 0, 0, 0, 8, 1,  0, 0, 0, 0, 0);
      step(1, 8, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      step(0, 8, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 8, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 8, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Producer side of the D/E-stage operand forwarding path in the 5-stage pipeline.
- Tracks destination register and remaining-latency (Tnew) records for instructions in E, M and W.
- From those records, generates the 2-bit forwarding-mux selects for the D and E operand muxes, plus the pipeline stall.
- Select encoding, shared with all forwarding muxes: 2 = M-stage forward value, 1 = W-stage forward value, 0 = stage's own register-file value.

Parameters:
ADDR_W, 5, register address width
TNEW_W, 2, Tnew/Tuse counter width

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
D_rs  input  ADDR_W  rs field of instruction in D
D_rt  input  ADDR_W  rt field of instruction in D
D_Tuse_rs  input  TNEW_W  cycles after D at which rs is consumed (0 = in D, 1 = in E, 2 = in M)
D_Tuse_rt  input  TNEW_W  same for rt
D_A3  input  ADDR_W  destination register of D instruction (0 = none)
D_TnewE  input  TNEW_W  cycles until result ready once instruction is in E (ALU 1, load 2, jal 0)
stall  output  1  freeze PC/F/D registers, insert bubble into E
D_ForwardRD1Mux_Sel  output  2  D-stage rs select
D_ForwardRD2Mux_Sel  output  2  D-stage rt select
E_ForwardRD1Mux_Sel  output  2  E-stage rs select
E_ForwardRD2Mux_Sel  output  2  E-stage rt select

Behaviour:
- Internal stage records:
  - E: rs, rt, A3, Tnew.
  - M: A3, Tnew.
  - W: A3 only; W data is always ready.
- Reset (reset==0, asynchronous): all records clear to zero, i.e. A3=0 bubbles. All selects 0 and stall 0 while in reset and in the cycle after release.
- Every rising edge, reset high:
  - M <= E, with Tnew = E.Tnew - 1, saturating at 0.
  - W <= M.
  - If stall==0: E <= {D_rs, D_rt, D_A3, D_TnewE}.
  - If stall==1: E <= bubble (all fields 0). D inputs are held by upstream logic.
- Match rule: stage X matches register r iff X.A3 == r and r != 0. Register 0 never matches, never forwards, never stalls.
- Stall is combinational from the current records and D inputs. For each D source r ∈ {rs, rt} with its Tuse:
  - stall if E matches r and (E.Tnew > Tuse or Tuse == 0). There is no E→D forward path.
  - stall if M matches r and M.Tnew > Tuse.
  - stall = OR over both sources.
- D select per source:
  - 2 if M matches and M.Tnew == 0;
  - else 1 if W matches;
  - else 0.
- E select: same rule using E.rs / E.rt against the M and W records.
- Priority: M over W when both match (younger value wins).
- Selects are purely combinational; no added latency.
- A stall cycle does not alter the selects; they are still evaluated from the current records.
- Consumer with Tuse=2 (store data) is never stalled by an E load; its forwarding is handled downstream.
- Saturation: Tnew never underflows. A 0 in E stays 0 in M.

Decomposition:
- Shared package `pipe_pkg`:
  - FWD_RF=0, FWD_W=1, FWD_M=2 select constants.
  - ADDR_W and TNEW_W.
  - Stage-record struct {rs, rt, a3, tnew}.
- One natural sub-module, `fwd_sel_gen`: combinational match/priority logic for one source, instantiated four times.
- Stall logic and the record registers stay in the top.

Test Plan:
- Reset asserted mid-run with records loaded -> immediately stall=0 and all selects 0. First post-reset cycle is still 0.
- ALU writes $8 (TnewE=1); next instruction reads rs=$8 with Tuse=1 -> stall=0. Next cycle E_ForwardRD1Mux_Sel=2. Cycle after, with the consumer now in M, a third reader in E sees sel=1 from W.
- Load writes $9 (TnewE=2); following beq reads rt=$9 with Tuse=0 -> stall=1 for exactly 2 cycles. Then D_ForwardRD2Mux_Sel=1 (load in W); E receives two bubbles.
- Load to $9, then ALU consumer with Tuse=1 -> stall 1 cycle. Then E_ForwardRD1Mux_Sel=2 is not raised (M.Tnew=1) and the consumer is held. After the load reaches W: sel=1, stall=0.
- jal writes $31 (TnewE=0); next jr reads rs=$31 with Tuse=0 -> stall 1 cycle. Then D_ForwardRD1Mux_Sel=2.
- Writes to $0 by any stage, with readers of $0 -> stall=0 and all selects 0. M and W both writing $5, reader of $5 -> sel=2.
